// File: rtl/bd_pkg.sv
// rtl/bd_pkg.sv - shared types and constants for the bd_rx_stream receiver
//
// Contents:
//   rx_state_e   framing FSM states (IDLE, START, DATA, STOP)
//   CTRL_*       bit positions inside the host CTRL byte
//   fifo_cnt_w() width of a FIFO occupancy counter able to hold 0..depth
package bd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_FLUSH_BIT   = 1;
    localparam int CTRL_IRQ_CLR_BIT = 2;
    localparam int CTRL_RSVD_BIT    = 3;
    localparam int CTRL_IRQ_LVL_LSB = 4;
    localparam int CTRL_IRQ_LVL_W   = 4;

    // Occupancy runs 0..depth inclusive, hence depth+1 distinct values.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bd_rx_fifo.sv
// rtl/bd_rx_fifo.sv - first-word-fall-through receive FIFO
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write request and word
//   pop               read request (head word consumed)
//   flush             empty the FIFO this cycle; push/pop in the same cycle are ignored
//   head              current head word, forced to 0 while empty
//   full, empty       occupancy flags
//   count             occupancy 0..FIFO_DEPTH
module bd_rx_fifo
    import bd_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int CNT_W     = fifo_cnt_w(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    // Depth is a power of two, so pointers wrap naturally on overflow.
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        // A push into a full FIFO is only taken when the head leaves in the same cycle.
        do_push  = push && !flush && (!full || pop);
        do_pop   = pop && !flush && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/bd_rx_stream.sv
// rtl/bd_rx_stream.sv - oversampled serial receiver with slicer, framing FSM and RX FIFO
//
// Ports:
//   G_CLK_RX      single clock, rising edge
//   RST_RX        synchronous active-high reset
//   ADC           one ADC sample per clock, sliced against THRESH
//   cfg_valid/cfg_ready/cfg_data   host CTRL byte: bit0 EN, bit1 FLUSH, bit2 IRQ_CLR, [7:4] IRQ_LVL
//   valid_out/ready_out/data_out   decoded word stream from the FIFO head
//   int_rx_host   registered level interrupt: FIFO level reached, overflow or framing error
module bd_rx_stream
    import bd_pkg::*;
#(
    parameter int ADC_W      = 8,
    parameter int DATA_W     = 8,
    parameter int SPS        = 4,
    parameter int THRESH     = 2 ** (ADC_W - 1),
    parameter int FIFO_DEPTH = 16
) (
    input  logic              G_CLK_RX,
    input  logic              RST_RX,
    input  logic [ADC_W-1:0]  ADC,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [7:0]        cfg_data,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [DATA_W-1:0] data_out,
    output logic              int_rx_host
);

    localparam int SMP_W = $clog2(SPS);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CNT_W = fifo_cnt_w(FIFO_DEPTH);
    // One extra bit so a THRESH of 2**ADC_W (never high) stays representable.
    localparam logic [ADC_W:0] THRESH_L = (ADC_W + 1)'(THRESH);

    rx_state_e                 state_q, state_d;
    logic [SMP_W-1:0]          smp_q, smp_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [DATA_W-1:0]         shift_q, shift_d;
    logic                      en_q, en_d;
    logic [CTRL_IRQ_LVL_W-1:0] lvl_q, lvl_d;
    logic                      ovf_q, ovf_d;
    logic                      ferr_q, ferr_d;
    logic                      int_q, int_d;

    logic             slice;
    logic             cfg_acc;
    logic             flush;
    logic             irq_clr;
    logic             push;
    logic             ferr_set;
    logic             ovf_set;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             cfg_unused;

    // The receiver never back-pressures the host.
    assign cfg_ready   = 1'b1;
    assign cfg_acc     = cfg_valid && cfg_ready;
    assign flush       = cfg_acc && cfg_data[CTRL_FLUSH_BIT];
    assign irq_clr     = cfg_acc && cfg_data[CTRL_IRQ_CLR_BIT];
    assign cfg_unused  = cfg_data[CTRL_RSVD_BIT];

    assign slice       = ({1'b0, ADC} >= THRESH_L);
    assign valid_out   = !fifo_empty;
    assign pop         = valid_out && ready_out;
    assign ovf_set     = push && !flush && fifo_full && !pop;
    assign int_rx_host = int_q;

    bd_rx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (G_CLK_RX),
        .rst       (RST_RX),
        .push      (push),
        .push_data (shift_q),
        .pop       (pop),
        .flush     (flush),
        .head      (data_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Framing: samples counted from the first low sample, so the START check
    // and each later bit decision land in the middle of their bit cell.
    always_comb begin
        state_d  = state_q;
        smp_d    = smp_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        if (!en_q) begin
            state_d = ST_IDLE;
            smp_d   = '0;
            bit_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!slice) begin
                        state_d = ST_START;
                        smp_d   = '0;
                    end
                end
                ST_START: begin
                    if (smp_q == SMP_W'(SPS / 2 - 1)) begin
                        smp_d   = '0;
                        bit_d   = '0;
                        state_d = slice ? ST_IDLE : ST_DATA;
                    end else begin
                        smp_d = smp_q + SMP_W'(1);
                    end
                end
                ST_DATA: begin
                    if (smp_q == SMP_W'(SPS - 1)) begin
                        smp_d   = '0;
                        shift_d = {slice, shift_q[DATA_W-1:1]};
                        if (bit_q == BIT_W'(DATA_W - 1)) begin
                            bit_d   = '0;
                            state_d = ST_STOP;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        smp_d = smp_q + SMP_W'(1);
                    end
                end
                ST_STOP: begin
                    if (smp_q == SMP_W'(SPS - 1)) begin
                        smp_d    = '0;
                        state_d  = ST_IDLE;
                        push     = slice;
                        ferr_set = !slice;
                    end else begin
                        smp_d = smp_q + SMP_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        en_d  = en_q;
        lvl_d = lvl_q;
        if (cfg_acc) begin
            en_d  = cfg_data[CTRL_EN_BIT];
            lvl_d = cfg_data[CTRL_IRQ_LVL_LSB +: CTRL_IRQ_LVL_W];
        end
        // Set beats clear when both happen in the same cycle.
        ovf_d  = ovf_set  ? 1'b1 : (irq_clr ? 1'b0 : ovf_q);
        ferr_d = ferr_set ? 1'b1 : (irq_clr ? 1'b0 : ferr_q);
        int_d  = ((lvl_q != '0) && (32'(fifo_count) >= 32'(lvl_q))) || ovf_q || ferr_q;
    end

    always_ff @(posedge G_CLK_RX) begin
        if (RST_RX) begin
            state_q <= ST_IDLE;
            smp_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            en_q    <= 1'b0;
            lvl_q   <= '0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            smp_q   <= smp_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            en_q    <= en_d;
            lvl_q   <= lvl_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
            int_q   <= int_d;
        end
    end

endmodule

// File: tb/tb_bd_rx_stream.sv
// tb/tb_bd_rx_stream.sv - directed self-checking bench for bd_rx_stream
module tb_bd_rx_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] adc;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_data;
    logic       valid_out;
    logic       ready_out;
    logic [7:0] data_out;
    logic       int_rx_host;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bd_rx_stream dut (
        .G_CLK_RX    (clk),
        .RST_RX      (rst),
        .ADC         (adc),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_data    (cfg_data),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .data_out    (data_out),
        .int_rx_host (int_rx_host)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic write_ctrl(input logic [7:0] b);
        cfg_valid = 1'b1;
        cfg_data  = b;
        tick;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
    endtask

    // SPS=4 frame: samples 0-3 start, 4-35 data LSB first, 36-39 stop.
    function automatic logic [7:0] frame_sample(input logic [7:0] b, input logic stop_bit, input int k);
        if (k < 4)  return 8'h00;
        if (k < 36) return b[(k - 4) / 4] ? 8'hFF : 8'h00;
        return stop_bit ? 8'hFF : 8'h00;
    endfunction

    task automatic send_samples(input logic [7:0] b, input logic stop_bit, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            adc = frame_sample(b, stop_bit, k);
            tick;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        send_samples(b, stop_bit, 0, 39);
    endtask

    task automatic idle(input int n);
        adc = 8'hFF;
        repeat (n) tick;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, valid_out, 1'b0);
        check_eq({tag, "_data"}, data_out, 8'h00);
        check_eq({tag, "_int"}, int_rx_host, 1'b0);
        check_eq({tag, "_cfg_ready"}, cfg_ready, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        adc       = 8'hFF;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        ready_out = 1'b0;
        tick;
        tick;
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        tick;
        check_reset_outputs("rst_rel");

        // Basic frame and STOP-to-valid latency.
        write_ctrl(8'h01);
        idle(2);
        send_samples(8'hA5, 1'b1, 0, 37);
        check_eq("a5_before_stop", valid_out, 1'b0);
        send_samples(8'hA5, 1'b1, 38, 38);
        check_eq("a5_valid", valid_out, 1'b1);
        check_eq("a5_data", data_out, 8'hA5);
        send_samples(8'hA5, 1'b1, 39, 39);
        ready_out = 1'b1;
        tick;
        ready_out = 1'b0;
        check_eq("a5_popped", valid_out, 1'b0);

        // Two-sample low glitch is rejected, receiver still decodes afterwards.
        do_reset;
        write_ctrl(8'h01);
        adc = 8'h00;
        tick;
        tick;
        idle(10);
        check_eq("glitch_valid", valid_out, 1'b0);
        check_eq("glitch_int", int_rx_host, 1'b0);
        send_frame(8'h5A, 1'b1);
        idle(2);
        check_eq("post_glitch_valid", valid_out, 1'b1);
        check_eq("post_glitch_data", data_out, 8'h5A);

        // Framing error: no push, sticky FERR raises the interrupt, IRQ_CLR drops it.
        do_reset;
        write_ctrl(8'h01);
        send_frame(8'h3C, 1'b0);
        idle(6);
        check_eq("ferr_valid", valid_out, 1'b0);
        check_eq("ferr_int", int_rx_host, 1'b1);
        write_ctrl(8'h05);
        check_eq("ferr_int_latency", int_rx_host, 1'b1);
        tick;
        check_eq("ferr_cleared", int_rx_host, 1'b0);

        // Overflow: 17 frames into a 16-deep FIFO with no reader.
        do_reset;
        write_ctrl(8'h01);
        ready_out = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send_frame(8'h10 + 8'(i), 1'b1);
            if (i == 15) begin
                idle(2);
                check_eq("full_no_int", int_rx_host, 1'b0);
            end
        end
        idle(2);
        check_eq("ovf_int", int_rx_host, 1'b1);
        ready_out = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("drain_valid_%0d", i), valid_out, 1'b1);
            check_eq($sformatf("drain_data_%0d", i), data_out, 8'h10 + 8'(i));
            tick;
        end
        ready_out = 1'b0;
        check_eq("drain_empty", valid_out, 1'b0);
        check_eq("ovf_sticky", int_rx_host, 1'b1);

        // Level interrupt at IRQ_LVL=4, then FLUSH.
        do_reset;
        write_ctrl(8'h41);
        for (int i = 0; i < 3; i++) send_frame(8'hC0 + 8'(i), 1'b1);
        idle(2);
        check_eq("lvl3_int", int_rx_host, 1'b0);
        check_eq("lvl3_valid", valid_out, 1'b1);
        send_samples(8'hC3, 1'b1, 0, 38);
        check_eq("lvl4_int_at_push", int_rx_host, 1'b0);
        send_samples(8'hC3, 1'b1, 39, 39);
        check_eq("lvl4_int", int_rx_host, 1'b1);
        write_ctrl(8'h03);
        check_eq("flush_valid", valid_out, 1'b0);
        check_eq("flush_data", data_out, 8'h00);
        tick;
        check_eq("flush_int", int_rx_host, 1'b0);

        // EN dropped mid-DATA discards the partial word.
        do_reset;
        write_ctrl(8'h01);
        send_samples(8'h55, 1'b1, 0, 15);
        write_ctrl(8'h00);
        idle(6);
        check_eq("en_off_valid", valid_out, 1'b0);
        write_ctrl(8'h01);
        idle(2);
        send_frame(8'h81, 1'b1);
        idle(2);
        check_eq("en_on_valid", valid_out, 1'b1);
        check_eq("en_on_data", data_out, 8'h81);
        ready_out = 1'b1;
        tick;
        ready_out = 1'b0;
        check_eq("en_on_single", valid_out, 1'b0);

        // Reset pulse mid-frame with a stored word and a pending interrupt.
        ready_out = 1'b0;
        send_frame(8'h42, 1'b1);
        send_frame(8'h3C, 1'b0);
        idle(6);
        check_eq("pre_rst_valid", valid_out, 1'b1);
        check_eq("pre_rst_int", int_rx_host, 1'b1);
        send_samples(8'h81, 1'b1, 0, 19);
        rst = 1'b1;
        tick;
        check_reset_outputs("rst_mid");
        tick;
        rst = 1'b0;
        tick;
        check_reset_outputs("rst_after");
        send_frame(8'h81, 1'b1);
        idle(2);
        check_eq("rst_en_cleared", valid_out, 1'b0);
        check_eq("rst_en_int", int_rx_host, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bd_rx_stream.md
BD_RX_STREAM -- requirements
Module: bd_rx_stream

Interface
REQ-001 SHALL have parameter ADC_W, default 8, meaning ADC sample width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning decoded word width.
REQ-003 SHALL have parameter SPS, default 4, meaning ADC samples per bit; it is even and ≥2.
REQ-004 SHALL have parameter THRESH, default 2**(ADC_W-1), meaning slicer threshold.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, meaning RX FIFO entries; it is a power of 2 and ≤16.
REQ-006 SHALL have port G_CLK_RX, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port RST_RX, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port ADC, input, ADC_W bits: one sample per clock.
REQ-009 SHALL have port cfg_valid, input, 1 bit: host control byte valid.
REQ-010 SHALL have port cfg_ready, output, 1 bit: control byte accepted.
REQ-011 SHALL have port cfg_data, input, 8 bits: CTRL byte, bit0 EN, bit1 FLUSH, bit2 IRQ_CLR, bits[7:4] IRQ_LVL.
REQ-012 SHALL have port valid_out, output, 1 bit: decoded word available.
REQ-013 SHALL have port ready_out, input, 1 bit: host accepts word.
REQ-014 SHALL have port data_out, output, DATA_W bits: FIFO head word.
REQ-015 SHALL have port int_rx_host, output, 1 bit: level interrupt to host.

Function
REQ-016 SHALL slice each sample to bit = (ADC >= THRESH).
REQ-017 SHALL hold cfg_ready at 1 after reset; a byte is accepted when cfg_valid=1 and cfg_ready=1.
REQ-018 SHALL latch EN and IRQ_LVL when a byte is accepted; FLUSH and IRQ_CLR are single-cycle strobes and are not stored.
REQ-019 SHALL run the framing FSM with states IDLE, START, DATA, STOP, using a sample counter 0..SPS-1 and a bit counter 0..DATA_W-1.
REQ-020 SHALL transition IDLE->START on slice=0 while EN=1.
REQ-021 SHALL, in START after SPS/2 samples, go to DATA if slice=0, else return to IDLE as a glitch.
REQ-022 SHALL, in DATA, sample every SPS clocks and shift the bit in LSB first; after DATA_W bits it goes to STOP.
REQ-023 SHALL, in STOP after SPS samples, push the word if slice=1; if slice=0 it sets sticky FERR and drops the word; both outcomes go to IDLE.
REQ-024 SHALL force the FSM to IDLE on the next clock when EN=0, including mid-frame, discarding the partial word.
REQ-025 SHALL implement the FIFO as first-word-fall-through: valid_out = !empty, data_out = head, pop on valid_out & ready_out.
REQ-026 SHALL, when a push occurs while full without a pop, drop the word and set sticky OVF.
REQ-027 SHALL accept both a simultaneous push and pop when full, leaving count unchanged.
REQ-028 SHALL empty the FIFO on a FLUSH strobe in the same cycle; any push or pop in that cycle is ignored; OVF is unaffected.
REQ-029 SHALL wrap read/write pointers modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-030 SHALL register int_rx_host = ((IRQ_LVL≠0) & (count ≥ IRQ_LVL)) | OVF | FERR, giving 1-cycle latency.
REQ-031 SHALL clear OVF and FERR on IRQ_CLR; if a set event occurs in the same cycle, the set wins.
REQ-032 SHALL give a latency of exactly 1 clock from the STOP sample to valid_out=1 with an empty FIFO.

Reset
REQ-033 SHALL, on RST_RX=1 at a clock edge, set FSM=IDLE, counters=0, EN=0, IRQ_LVL=0, FIFO empty, OVF=0, FERR=0.
REQ-034 SHALL drive outputs during and after reset as: valid_out=0, data_out=0, int_rx_host=0, cfg_ready=1.
REQ-035 SHALL let reset take priority over every other event, including mid-frame and mid-handshake.

Structure
REQ-036 SHALL place the FSM state enum, CTRL bit positions (EN/FLUSH/IRQ_CLR/IRQ_LVL) and the FIFO count width function in shared package bd_pkg.
REQ-037 SHALL implement the FIFO as sub-module bd_rx_fifo, parametrised by DATA_W and FIFO_DEPTH, with push/pop/flush/full/empty/count ports.

Verification
REQ-038 SHALL cover: write CTRL 0x01, ADC frames byte 0xA5 (SPS=4, 0x00 for 0, 0xFF for 1) -> valid_out=1, data_out=0xA5 one clock after STOP sample.
REQ-039 SHALL cover: 2-sample low glitch on ADC in IDLE -> FSM returns IDLE, no push, valid_out stays 0.
REQ-040 SHALL cover: frame 0x3C with stop bit 0 -> no push, int_rx_host=1; then CTRL 0x05 -> int_rx_host=0.
REQ-041 SHALL cover: ready_out=0, 17 frames with FIFO_DEPTH=16 -> count=16, 17th dropped, int_rx_host=1; drain yields the first 16 bytes in order.
REQ-042 SHALL cover: CTRL 0x41 (IRQ_LVL=4), 3 frames then 4 -> int_rx_host 0 after the third, 1 one clock after the fourth push; CTRL 0x03 (FLUSH) -> valid_out=0, int_rx_host=0.
REQ-043 SHALL cover: CTRL 0x00 mid-DATA, then 0x01 and a full frame 0x81 -> only 0x81 is delivered; RST_RX pulse mid-frame -> all outputs at reset values.
